byte_word_pack: RTL and testbench



---
 rtl/byte_word_pack_if.sv | 32 +++
 rtl/byte_word_pack.sv | 113 +++++++++++
 tb/tb_byte_word_pack.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_word_pack_if.sv
// byte_word_pack_if
//   Bundles the byte-side and word-side handshakes of the byte-to-word packer.
//   master : the environment. It drives bytes, flush and word_ready, and it
//            observes byte_ready and the word outputs.
//   slave  : the packer itself.
//   Signals:
//     byte_in/byte_valid/byte_ready        incoming byte stream
//     flush                                request to emit the partial word
//     word_out/word_bcnt/word_valid/word_ready  outgoing word stream
interface byte_word_pack_if #(
  parameter int BW = 8,
  parameter int NB = 4
);
  logic [BW-1:0]    byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             flush;
  logic [BW*NB-1:0] word_out;
  logic [2:0]       word_bcnt;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output byte_in, byte_valid, flush, word_ready,
    input  byte_ready, word_out, word_bcnt, word_valid
  );

  modport slave (
    input  byte_in, byte_valid, flush, word_ready,
    output byte_ready, word_out, word_bcnt, word_valid
  );
endinterface

// File: rtl/byte_word_pack.sv
// byte_word_pack
//   Collects bytes into NB-byte words. The first byte of a word lands in the
//   least significant lane. Completed words are handed out over a valid/ready
//   port. A flush emits the partial word zero-padded, together with its byte
//   count.
//   Ports:
//     clk     rising-edge clock
//     resetn  synchronous reset, ACTIVE HIGH despite the name
//     bus     byte_word_pack_if.slave (byte and word handshakes, flush)
module byte_word_pack #(
  parameter int BW = 8,
  parameter int NB = 4
) (
  input logic             clk,
  input logic             resetn,
  byte_word_pack_if.slave bus
);
  localparam int         WW     = BW * NB;
  localparam logic [2:0] NB_C   = 3'(NB);
  localparam logic [2:0] LAST_C = 3'(NB - 1);

  logic [2:0]    cnt_q, cnt_d;
  logic [WW-1:0] acc_q, acc_d;
  logic          pend_q, pend_d;
  logic [WW-1:0] word_q, word_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          wvalid_q, wvalid_d;

  logic          slot_free_s;
  logic          byte_ready_s;
  logic          byte_acc_s;
  logic [WW-1:0] acc_p_s;
  logic [2:0]    cnt_p_s;
  logic          load_s;

  // Handshake qualifiers. The output slot can drain and refill on the same edge.
  always_comb begin
    slot_free_s  = !wvalid_q | bus.word_ready;
    byte_ready_s = !resetn & !pend_q & ((cnt_q != LAST_C) | slot_free_s);
    byte_acc_s   = bus.byte_valid & byte_ready_s;
  end

  // Next state: place the accepted byte, then resolve a full word or a flush.
  always_comb begin
    // Accumulator and count as they stand once this cycle's byte is included.
    for (int k = 0; k < NB; k++) begin
      acc_p_s[k*BW +: BW] = (byte_acc_s && (cnt_q == 3'(k))) ? bus.byte_in
                                                             : acc_q[k*BW +: BW];
    end
    cnt_p_s = cnt_q + {2'b00, byte_acc_s};

    cnt_d  = cnt_p_s;
    acc_d  = acc_p_s;
    pend_d = 1'b0;
    word_d = word_q;
    bcnt_d = bcnt_q;
    load_s = 1'b0;

    if (cnt_p_s == NB_C) begin
      // A full word needs a free slot; byte_ready already guaranteed it.
      word_d = acc_p_s;
      bcnt_d = NB_C;
      load_s = 1'b1;
      cnt_d  = 3'd0;
      acc_d  = '0;
    end else if ((bus.flush | pend_q) && (cnt_p_s != 3'd0)) begin
      // Unused lanes of acc are always zero, so the word is already padded.
      if (slot_free_s) begin
        word_d = acc_p_s;
        bcnt_d = cnt_p_s;
        load_s = 1'b1;
        cnt_d  = 3'd0;
        acc_d  = '0;
      end else begin
        pend_d = 1'b1;
      end
    end else begin
      pend_d = 1'b0;
    end

    if (load_s) begin
      wvalid_d = 1'b1;
    end else if (wvalid_q && bus.word_ready) begin
      wvalid_d = 1'b0;
    end else begin
      wvalid_d = wvalid_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      cnt_q    <= 3'd0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      word_q   <= '0;
      bcnt_q   <= 3'd0;
      wvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign bus.byte_ready = byte_ready_s;
  assign bus.word_out   = word_q;
  assign bus.word_bcnt  = bcnt_q;
  assign bus.word_valid = wvalid_q;
endmodule

// File: tb/tb_byte_word_pack.sv
// tb_byte_word_pack
//   Drives the packer one cycle at a time. A queue-based reference model holds
//   the bytes of the partial word, the output slot and the pending-flush flag.
//   The model predicts byte_ready and the word outputs, and each scenario task
//   also checks the values the scenario is expected to produce.
module tb_byte_word_pack;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  byte_word_pack_if #(.BW(8), .NB(4)) bus ();

  byte_word_pack #(.BW(8), .NB(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  m_part[$];
  logic        m_vld  = 1'b0;
  logic [31:0] m_word = 32'h0;
  logic [2:0]  m_bcnt = 3'd0;
  logic        m_pend = 1'b0;

  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < q.size(); i++) r = r | (32'(q[i]) << (8 * i));
    return r;
  endfunction

  // One clock cycle: drive inputs, check byte_ready, advance the model, check outputs.
  task automatic cycle(input logic rst, input logic bv, input logic [7:0] b,
                       input logic fl, input logic wr);
    logic exp_rdy;
    logic slot_free;
    logic loaded;
    resetn         = rst;
    bus.byte_valid = bv;
    bus.byte_in    = b;
    bus.flush      = fl;
    bus.word_ready = wr;
    #1;
    slot_free = !m_vld || wr;
    exp_rdy   = !rst && !m_pend && ((m_part.size() != 3) || slot_free);
    n_checks++;
    if (bus.byte_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL byte_ready t=%0t got %b expected %b", $time, bus.byte_ready, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      m_part.delete();
      m_vld  = 1'b0;
      m_word = 32'h0;
      m_bcnt = 3'd0;
      m_pend = 1'b0;
    end else begin
      loaded = 1'b0;
      if (bv && exp_rdy) m_part.push_back(b);
      if (m_part.size() == 4) begin
        m_word = pack(m_part);
        m_bcnt = 3'd4;
        loaded = 1'b1;
        m_part.delete();
      end else if ((fl || m_pend) && m_part.size() != 0) begin
        if (slot_free) begin
          m_word = pack(m_part);
          m_bcnt = 3'(m_part.size());
          loaded = 1'b1;
          m_part.delete();
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
      if (loaded) m_vld = 1'b1;
      else if (m_vld && wr) m_vld = 1'b0;
    end
    #1;
    n_checks++;
    if (bus.word_valid !== m_vld) begin
      n_fail++;
      $display("FAIL word_valid t=%0t got %b expected %b", $time, bus.word_valid, m_vld);
    end
    if (m_vld) begin
      n_checks++;
      if (bus.word_out !== m_word) begin
        n_fail++;
        $display("FAIL word_out t=%0t got %h expected %h", $time, bus.word_out, m_word);
      end
      n_checks++;
      if (bus.word_bcnt !== m_bcnt) begin
        n_fail++;
        $display("FAIL word_bcnt t=%0t got %0d expected %0d", $time, bus.word_bcnt, m_bcnt);
      end
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (bus.word_out !== 32'h0 || bus.word_bcnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%0d expected 00000000/0", bus.word_out, bus.word_bcnt);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes_v [4];
    bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, bytes_v[i], 1'b0, 1'b1);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h44332211 || bus.word_bcnt !== 3'd4) begin
      n_fail++;
      $display("FAIL single_word got %b/%h/%0d expected 1/44332211/4",
               bus.word_valid, bus.word_out, bus.word_bcnt);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_word_hold got %b expected 0", bus.word_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
      if (i == 4 || i == 8) begin
        n_checks++;
        if (bus.word_out !== ((i == 4) ? 32'h04030201 : 32'h08070605) || bus.word_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back word %0d got %b/%h", i / 4, bus.word_valid, bus.word_out);
        end
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] first_v [4];
    logic [7:0] next_v [3];
    first_v = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    next_v  = '{8'hEE, 8'hFF, 8'h10};
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, first_v[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, next_v[i], 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    n_checks++;
    if (bus.word_out !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL backpressure_hold got %h expected ddccbbaa", bus.word_out);
    end
    cycle(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
    n_checks++;
    if (bus.word_out !== 32'h2010FFEE || bus.word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_next got %b/%h expected 1/2010ffee", bus.word_valid, bus.word_out);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hB2, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (bus.word_out !== 32'h0000B2A1 || bus.word_bcnt !== 3'd2 || bus.word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_partial got %b/%h/%0d expected 1/0000b2a1/2",
               bus.word_valid, bus.word_out, bus.word_bcnt);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty got %b expected 0", bus.word_valid);
    end
  endtask

  task automatic test_flush_pending();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h5B, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if (bus.word_out !== 32'hC3C2C1C0) begin
      n_fail++;
      $display("FAIL flush_pend_hold got %h expected c3c2c1c0", bus.word_out);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (bus.word_out !== 32'h005C5B5A || bus.word_bcnt !== 3'd3 || bus.word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pend_word got %b/%h/%0d expected 1/005c5b5a/3",
               bus.word_valid, bus.word_out, bus.word_bcnt);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h90, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hE2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hE3, 1'b1, 1'b0);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_valid got %b expected 0", bus.word_valid);
    end
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
    n_checks++;
    if (bus.word_out !== 32'h04030201 || bus.word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_word got %b/%h expected 1/04030201", bus.word_valid, bus.word_out);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_pending();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
